// File: rtl/video_stream_pixel_repack.sv
// Avalon-ST pixel repacker: maps DIN_CH-channel beats onto DOUT_CH-channel beats,
// filters beats arriving outside a packet, and buffers through a two-entry skid.
module video_stream_pixel_repack #(
    parameter int BPC = 8,
    parameter int DIN_CH = 3,
    parameter int DOUT_CH = 4,
    parameter int PAD_MODE = 0,
    parameter logic [BPC-1:0] ALPHA_VALUE = {BPC{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BPC*DIN_CH-1:0]  din_data,
    input  logic                   din_valid,
    input  logic                   din_startofpacket,
    input  logic                   din_endofpacket,
    output logic                   din_ready,
    output logic [BPC*DOUT_CH-1:0] dout_data,
    output logic                   dout_valid,
    output logic                   dout_startofpacket,
    output logic                   dout_endofpacket,
    input  logic                   dout_ready,
    output logic                   err_sticky,
    output logic [15:0]            drop_count
);

    localparam int OW = BPC*DOUT_CH;

    // state             | meaning
    // WAIT_SOP          | idle, expecting a header beat; non-SOP beats are dropped
    // HEADER_DONE_VIDEO | inside a video packet (type 0); payload gets PAD_MODE fill
    // HEADER_DONE_OTHER | inside a non-video packet; padding is always zero
    typedef enum logic [1:0] {
        WAIT_SOP,
        HEADER_DONE_VIDEO,
        HEADER_DONE_OTHER
    } state_t;

    state_t state, state_next;

    logic          take_in;
    logic          keep;
    logic          err_set;
    logic          drop_inc;
    logic          video_payload;
    logic [BPC-1:0] pad_val;
    logic [OW-1:0] pix;

    logic          out_free;
    logic          full_next;
    logic [OW-1:0] skid_data;
    logic          skid_sop;
    logic          skid_eop;
    logic          skid_valid;

    assign take_in = din_valid & din_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_SOP;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        keep          = 1'b0;
        err_set       = 1'b0;
        drop_inc      = 1'b0;
        video_payload = (state == HEADER_DONE_VIDEO) && !din_startofpacket;
        if (take_in) begin
            if (din_startofpacket) begin
                keep    = 1'b1;
                err_set = (state != WAIT_SOP);
                if (din_endofpacket)
                    state_next = WAIT_SOP;
                else if (din_data[3:0] == 4'h0)
                    state_next = HEADER_DONE_VIDEO;
                else
                    state_next = HEADER_DONE_OTHER;
            end else if (state == WAIT_SOP) begin
                drop_inc = 1'b1;
                err_set  = 1'b1;
            end else begin
                keep = 1'b1;
                if (din_endofpacket) state_next = WAIT_SOP;
            end
        end
    end

    assign pad_val = (PAD_MODE == 1 && video_payload) ? ALPHA_VALUE : '0;

    // Low channels copy straight across; surplus input channels are simply not routed.
    for (genvar g = 0; g < DOUT_CH; g++) begin : g_ch
        if (g < DIN_CH) begin : g_copy
            assign pix[g*BPC +: BPC] = din_data[g*BPC +: BPC];
        end else begin : g_pad
            assign pix[g*BPC +: BPC] = pad_val;
        end
    end

    // The output register is the first buffer entry, the skid register the second.
    assign out_free  = !dout_valid || dout_ready;
    assign full_next = out_free ? (skid_valid & keep) : (skid_valid | keep);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_data          <= '0;
            dout_valid         <= 1'b0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
            skid_data          <= '0;
            skid_sop           <= 1'b0;
            skid_eop           <= 1'b0;
            skid_valid         <= 1'b0;
            din_ready          <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    dout_data          <= skid_data;
                    dout_startofpacket <= skid_sop;
                    dout_endofpacket   <= skid_eop;
                    dout_valid         <= 1'b1;
                    skid_valid         <= keep;
                    if (keep) begin
                        skid_data <= pix;
                        skid_sop  <= din_startofpacket;
                        skid_eop  <= din_endofpacket;
                    end
                end else if (keep) begin
                    dout_data          <= pix;
                    dout_startofpacket <= din_startofpacket;
                    dout_endofpacket   <= din_endofpacket;
                    dout_valid         <= 1'b1;
                end else begin
                    dout_valid <= 1'b0;
                end
            end else if (keep) begin
                skid_data  <= pix;
                skid_sop   <= din_startofpacket;
                skid_eop   <= din_endofpacket;
                skid_valid <= 1'b1;
            end
            din_ready <= !full_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
            drop_count <= '0;
        end else begin
            if (err_set) err_sticky <= 1'b1;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule
